// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared widths, VRAM ownership encoding and host request sizing
// Rev 1.0
// ============================================================================
package vga_pkg;

    localparam int VRAM_ADDR_W = 12;
    localparam int VRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_SCAN    = 2'd1,
        OWN_HOST_RD = 2'd2
    } owner_e;

    // Packed host request is {we, be[1:0], addr, wdata}
    function automatic int host_req_w(input int aw, input int dw);
        return 3 + aw + dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_req_fifo.sv
`default_nettype none
// ============================================================================
// vga_req_fifo : in-order synchronous request queue with registered ready
// Rev 1.0
// ============================================================================
module vga_req_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic             pixclk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ready;
    logic             w_do_push;
    logic             w_do_pop;
    logic [CNT_W-1:0] w_count_nxt;

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_head      = r_mem[r_rd_ptr];
    assign o_ready     = r_ready;

    assign w_do_pop    = i_pop && !o_empty;
    assign w_do_push   = i_push && (!o_full || w_do_pop);
    assign w_count_nxt = r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge pixclk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge pixclk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/vga_vram_arbiter.sv
`default_nettype none
// ============================================================================
// vga_vram_arbiter : single-port VRAM sharing, scanout absolute priority,
//                    host requests queued in order and issued in free cycles
// Rev 1.0
// ============================================================================
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 64
) (
    input  logic              pixclk,
    input  logic              resetn,
    input  logic              i_scan_req,
    input  logic [ADDR_W-1:0] i_scan_addr,
    output logic              o_scan_valid,
    output logic [DATA_W-1:0] o_scan_data,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    input  logic              i_host_we,
    input  logic [1:0]        i_host_be,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [1:0]        o_mem_be,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_stat_clr,
    output logic              o_stat_starve
);

    localparam int REQ_W  = host_req_w(ADDR_W, DATA_W);
    localparam int WAIT_W = $clog2(STARVE_MAX + 1);

    logic [REQ_W-1:0]  w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_ready;
    logic              w_push;
    logic              w_host_issue;
    logic              w_head_we;
    logic [1:0]        w_head_be;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_wdata;
    owner_e            w_owner_nxt;
    owner_e            r_owner;
    logic [WAIT_W-1:0] r_wait;
    logic              r_starve;
    logic              w_wait_inc;
    logic              w_starve_set;

    assign w_push = i_host_valid && w_ready && !w_full;

    vga_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pixclk      (pixclk),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_push_data ({i_host_we, i_host_be, i_host_addr, i_host_wdata}),
        .i_pop       (w_host_issue),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_ready     (w_ready)
    );

    assign w_head_we    = w_head[REQ_W-1];
    assign w_head_be    = w_head[REQ_W-2 -: 2];
    assign w_head_addr  = w_head[DATA_W +: ADDR_W];
    assign w_head_wdata = w_head[DATA_W-1:0];

    // Grant mux: scanout always wins, otherwise drain the queue head
    always_comb begin
        o_mem_en     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_be     = 2'b00;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        w_host_issue = 1'b0;
        w_owner_nxt  = OWN_NONE;
        if (resetn) begin
            if (i_scan_req) begin
                o_mem_en    = 1'b1;
                o_mem_addr  = i_scan_addr;
                w_owner_nxt = OWN_SCAN;
            end else if (!w_empty) begin
                w_host_issue = 1'b1;
                o_mem_en     = 1'b1;
                o_mem_we     = w_head_we;
                o_mem_addr   = w_head_addr;
                if (w_head_we) begin
                    o_mem_be    = w_head_be;
                    o_mem_wdata = w_head_wdata;
                end else begin
                    w_owner_nxt = OWN_HOST_RD;
                end
            end
        end
    end

    assign w_wait_inc   = !w_empty && i_scan_req && (r_wait != WAIT_W'(STARVE_MAX));
    assign w_starve_set = w_wait_inc && (r_wait == WAIT_W'(STARVE_MAX - 1));

    always_ff @(posedge pixclk) begin
        if (!resetn) begin
            r_owner  <= OWN_NONE;
            r_wait   <= '0;
            r_starve <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            if (w_host_issue)    r_wait <= '0;
            else if (w_wait_inc) r_wait <= r_wait + 1'b1;
            if (w_starve_set)    r_starve <= 1'b1;
            else if (i_stat_clr) r_starve <= 1'b0;
        end
    end

    assign o_scan_valid  = resetn && (r_owner == OWN_SCAN);
    assign o_scan_data   = o_scan_valid ? i_mem_rdata : '0;
    assign o_host_rvalid = resetn && (r_owner == OWN_HOST_RD);
    assign o_host_rdata  = o_host_rvalid ? i_mem_rdata : '0;
    assign o_host_ready  = w_ready;
    assign o_stat_starve = r_starve;

endmodule
`default_nettype wire
